// File: rtl/div_iter_unit_if.sv
// Request/response bundle between the issue/writeback path and div_iter_unit.
// master = issuer side, slave = divider side.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface div_iter_unit_if #(
  parameter int TAG_W = 6
);
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_op;
  logic [`WORD_WIDTH-1:0] in_src1;
  logic [`WORD_WIDTH-1:0] in_src2;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [`WORD_WIDTH-1:0] out_data;
  logic [TAG_W-1:0]       out_tag;

  modport master (
    output flush, in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  flush, in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/div_iter_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU (op[0]=unsigned, op[1]=remainder).
// Define DIV_EARLY_OUT_EN to size the iteration count from the leading-one
// positions of the operands; otherwise every non-special op runs 32 iterations.
// Results are identical in both builds, only latency changes.
//
// state | meaning
// IDLE  | waiting for a request
// PREP  | align divisor under dividend, or take the |a| < |b| shortcut
// CALC  | one quotient bit per cycle
// FIX   | apply signs, select quotient/remainder into the output register
// DONE  | result held until out_ready
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module div_find_ones (
  input  logic [`WORD_WIDTH-1:0] i_data,
  output logic [4:0]             o_pos
);
  // index of the most significant set bit; zero input reports 0
  always_comb begin
    o_pos = '0;
    for (int i = 0; i < `WORD_WIDTH; i++) begin
      if (i_data[i]) o_pos = 5'(i);
    end
  end
endmodule

module div_iter_unit #(
  parameter int TAG_W = 6
) (
  input logic           clk,
  input logic           rst_n,
  div_iter_unit_if.slave bus
);
  localparam int W = `WORD_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [1:0]         r_op;
  logic [TAG_W-1:0]   r_tag;
  logic               r_neg_a, r_neg_b;
  logic [W-1:0]       r_abs_a, r_abs_b;
  logic [W-1:0]       r_rem, r_quo;
  logic [2*W-2:0]     r_dshift;
  logic [4:0]         r_count;
  logic [W-1:0]       r_out_data;
  logic [TAG_W-1:0]   r_out_tag;

  logic               w_accept, w_signed, w_neg_a, w_neg_b, w_div0, w_ovf;
  logic [W-1:0]       w_abs_a, w_abs_b;
  logic [4:0]         w_la, w_lb, w_count;
  logic               w_short, w_ge;
  logic [W-1:0]       w_q_fix, w_r_fix;

  assign bus.in_ready  = (r_state == S_IDLE) & ~bus.flush;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_data  = r_out_data;
  assign bus.out_tag   = r_out_tag;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_signed = ~bus.in_op[0];
  assign w_neg_a  = w_signed & bus.in_src1[W-1];
  assign w_neg_b  = w_signed & bus.in_src2[W-1];
  assign w_abs_a  = w_neg_a ? -bus.in_src1 : bus.in_src1;
  assign w_abs_b  = w_neg_b ? -bus.in_src2 : bus.in_src2;
  assign w_div0   = (bus.in_src2 == '0);
  assign w_ovf    = w_signed & (bus.in_src1 == {1'b1, {(W-1){1'b0}}}) & (bus.in_src2 == '1);

`ifdef DIV_EARLY_OUT_EN
  div_find_ones u_find_a (.i_data(r_abs_a), .o_pos(w_la));
  div_find_ones u_find_b (.i_data(r_abs_b), .o_pos(w_lb));
  assign w_short = (r_abs_a < r_abs_b);
`else
  assign w_la    = 5'd31;
  assign w_lb    = 5'd0;
  assign w_short = 1'b0;
`endif

  assign w_count = w_la - w_lb;
  assign w_ge    = ({{(W-1){1'b0}}, r_rem} >= r_dshift);
  assign w_q_fix = (~r_op[0] & (r_neg_a ^ r_neg_b)) ? -r_quo : r_quo;
  assign w_r_fix = r_neg_a ? -r_rem : r_rem;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state logic; flush overrides everything
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_div0 | w_ovf) ? S_DONE : S_PREP;
      S_PREP: w_next = w_short ? S_FIX : S_CALC;
      S_CALC: if (r_count == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.flush) w_next = S_IDLE;
  end

  // operand capture, iteration datapath and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_tag      <= '0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_abs_a    <= '0;
      r_abs_b    <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dshift   <= '0;
      r_count    <= '0;
      r_out_data <= '0;
      r_out_tag  <= '0;
    end else if (!bus.flush) begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op    <= bus.in_op;
          r_tag   <= bus.in_tag;
          r_neg_a <= w_neg_a;
          r_neg_b <= w_neg_b;
          r_abs_a <= w_abs_a;
          r_abs_b <= w_abs_b;
          // special cases bypass the iteration and land directly in DONE
          if (w_div0) begin
            r_out_data <= bus.in_op[1] ? bus.in_src1 : '1;
            r_out_tag  <= bus.in_tag;
          end else if (w_ovf) begin
            r_out_data <= bus.in_op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
            r_out_tag  <= bus.in_tag;
          end
        end
        S_PREP: begin
          r_rem    <= r_abs_a;
          r_quo    <= '0;
          r_count  <= w_count;
          r_dshift <= {{(W-1){1'b0}}, r_abs_b} << w_count;
        end
        S_CALC: begin
          // when rem >= dshift the shifted divisor fits in W bits
          if (w_ge) r_rem <= r_rem - r_dshift[W-1:0];
          r_quo    <= {r_quo[W-2:0], w_ge};
          r_dshift <= r_dshift >> 1;
          if (r_count != '0) r_count <= r_count - 5'd1;
        end
        S_FIX: begin
          r_out_data <= r_op[1] ? w_r_fix : w_q_fix;
          r_out_tag  <= r_tag;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed cases followed by random ops,
// compared against an arithmetic reference model. Latency expectations follow
// the DIV_EARLY_OUT_EN build setting.
module tb_div_iter_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  div_iter_unit_if #(.TAG_W(6)) bus ();

  div_iter_unit #(.TAG_W(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
      sa = a;
      sb = b;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? a % b : a / b;
  endfunction

  function automatic int msb_pos(input logic [31:0] x);
    int p = 0;
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    return p;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    ma = (!op[0] && a[31]) ? -a : a;
    mb = (!op[0] && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 3;
    return msb_pos(ma) - msb_pos(mb) + 4;
`else
    return 35;
`endif
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input int stall);
    logic [31:0] exp_d;
    int exp_lat, lat, w;
    exp_d   = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_issue", bus.in_ready, 1'b1);
    bus.out_ready = (stall == 0);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_src1   = a;
    bus.in_src2   = b;
    bus.in_tag    = tag;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("out_data", bus.out_data, exp_d);
    chk("out_tag", bus.out_tag, tag);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_out_valid", bus.out_valid, 1'b1);
      chk("stall_out_data", bus.out_data, exp_d);
      chk("stall_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_after_handshake", bus.out_valid, 1'b0);
  endtask

  initial begin
    int seen;
    logic [1:0]  op;
    logic [31:0] a, b;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out_data", bus.out_data, 32'h0);
    chk("reset_out_tag", bus.out_tag, 6'h0);
    chk("reset_in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", bus.in_ready, 1'b1);

    do_op(2'b01, 32'd100, 32'd7, 6'd1, 0);
    do_op(2'b00, -32'sd7, 32'd2, 6'd2, 0);
    do_op(2'b10, -32'sd7, 32'd2, 6'd3, 0);
    do_op(2'b10, 32'd7, -32'sd2, 6'd4, 0);
    do_op(2'b01, 32'd5, 32'd0, 6'd5, 0);
    do_op(2'b11, 32'd5, 32'd0, 6'd6, 0);
    do_op(2'b00, 32'hFFFF_FFFF, 32'd0, 6'd7, 0);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd8, 0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'd9, 0);
    do_op(2'b01, 32'd3, 32'd10, 6'd10, 0);
    do_op(2'b11, 32'd3, 32'd10, 6'd11, 0);
    do_op(2'b01, 32'd0, 32'd9, 6'd12, 0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 6'd13, 0);
    do_op(2'b00, 32'h8000_0000, 32'd1, 6'd14, 0);
    do_op(2'b01, 32'd1000, 32'd33, 6'd15, 5);

    // flush in the middle of the iteration
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b01;
    bus.in_src1  = 32'hFFFF_FFFF;
    bus.in_src2  = 32'd1;
    bus.in_tag   = 6'd20;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("flush_in_ready", bus.in_ready, 1'b1);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    // flush together with a request must not accept it
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_src2  = 32'd0;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_with_valid_in_ready", bus.in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("flush_no_result", 64'(seen), 64'd0);

    // random operations
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 255); b = $urandom_range(1, 255); end
        2: begin a = $urandom; b = $urandom_range(1, 15); end
        3: begin a = $urandom; b = 32'(-$urandom_range(1, 100)); end
        default: begin a = $urandom; b = ($urandom_range(0, 1) != 0) ? 32'd0 : 32'hFFFF_FFFF; end
      endcase
      do_op(op, a, b, 6'($urandom), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", checks - failed, checks);
    $finish;
  end
endmodule

// File: doc/div_iter_unit.md
# div_iter_unit

Iterative 32-bit integer divider for the execute stage, implementing DIV, DIVU, REM and REMU. It sits directly downstream of the leading-one detector `div_find_ones` and instantiates it twice, on |dividend| and |divisor|. The two bit positions set the start shift and iteration count, so short divisions finish early. Results return to the issue/writeback path through a valid/ready handshake carrying the instruction tag.

## Interface
- `TAG_W`, default 6: width of the tag carried with each operation.
- Data width is `` `WORD_WIDTH `` (32). It is not a parameter.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: kills the in-flight operation.
- `in_valid` input 1: a request is present.
- `in_ready` output 1: unit can accept; `(state==IDLE) & ~flush`.
- `in_op` input 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `in_src1` input 32: dividend.
- `in_src2` input 32: divisor.
- `in_tag` input TAG_W: tag returned with the result.
- `out_valid` output 1: result is present.
- `out_ready` input 1: consumer takes the result.
- `out_data` output 32: quotient or remainder, as selected by `in_op`.
- `out_tag` output TAG_W: tag of the result.

## Operation
- The FSM has five states: IDLE, PREP, CALC, FIX, DONE.
- **IDLE**
  - Accept when `in_valid & in_ready`.
  - On accept, register the op, the tag, the sign flags, |src1|, |src2| and the raw src1.
  - Signed ops take the two's-complement magnitude; unsigned ops take the value unchanged.
  - Divide by zero goes straight to DONE. The quotient is 0xFFFFFFFF; the remainder is the raw src1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF with DIV/REM) goes straight to DONE. The quotient is 0x80000000; the remainder is 0.
  - All other requests go to PREP.
- **PREP**
  - la = location_one(|a|), lb = location_one(|b|).
  - If |a| < |b|: quotient 0, remainder |a|, go to FIX. A zero dividend takes this path.
  - Otherwise: count = la − lb, dshift = |b| << count, and the remainder register is loaded with |a|. Go to CALC.
- **CALC**, one quotient bit per cycle:
  - If rem ≥ dshift, then rem −= dshift and the bit is 1; otherwise the bit is 0.
  - q = {q[30:0], bit}, dshift >>= 1.
  - Leave for FIX in the cycle where count == 0; otherwise count −= 1.
  - This gives n = la − lb + 1 iterations.
- **FIX**
  - Negate the quotient if the op is signed and the operand signs differ.
  - Give the remainder the dividend's sign.
  - Select the output by op and register it into `out_data`/`out_tag`, then go to DONE.
- **DONE**
  - `out_valid` = 1. `out_data` and `out_tag` hold stable until `out_ready`.
  - On `out_ready`, go to IDLE.
- **Widths**
  - Remainder register: 32 bits.
  - dshift: 63 bits (2·WORD_WIDTH−1).
  - count: 5 bits.
  - The comparison rem ≥ dshift is an unsigned compare over 63 bits.
- **Flush**
  - Flush in any state forces IDLE on the next edge and clears `out_valid`.
  - A result in DONE is discarded even if `out_ready` is high in the same cycle.
  - `flush` together with `in_valid` accepts nothing.
- **Reset**
  - state = IDLE.
  - `out_valid` = 0, `out_data` = 0, `out_tag` = 0.
  - All internal registers are 0; `in_ready` reads 1.
  - Reset asserted mid-operation discards that operation.

## Timing
- Accept happens in cycle T.
- Normal path:
  - PREP in T+1.
  - CALC in T+2 … T+1+n.
  - FIX in T+2+n.
  - `out_valid` first high in T+3+n.
- |a| < |b| path: `out_valid` is first high in T+3.
- Special cases (divide by zero, signed overflow): `out_valid` is first high in T+1.
- Back-to-back operation:
  - A new accept is possible in the cycle after the `out_ready` handshake.
  - There is no overlap between operations.
- There is no combinational path from the inputs to `out_valid`/`out_data`.

## Configuration
- `DIV_EARLY_OUT_EN`
  - **Defined:** PREP uses the `div_find_ones` results as above, so n = la − lb + 1.
  - **Undefined:**
    - The detectors are not instantiated.
    - PREP forces la = 31, lb = 0, so count = 31 and n = 32 for every non-special operation.
    - The |a| < |b| shortcut is also removed, so those operations take the full path.
    - Results are bit-identical in both configurations; only latency differs.

## Test plan
- DIVU 100 / 7, accepted at T:
  - Response: `out_data` = 14, `out_valid` at T+8 (n = 5).
  - With `DIV_EARLY_OUT_EN` undefined: `out_valid` at T+35.
- Signed sign handling:
  - DIV −7 / 2 → 0xFFFFFFFD.
  - REM −7 % 2 → 0xFFFFFFFF.
  - REM 7 % −2 → 1.
  - All with the tag echoed.
- Divide by zero:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REMU 5 % 0 → 5.
  - DIV −1 / 0 → 0xFFFFFFFF.
  - All with `out_valid` at T+1.
- Signed overflow:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1.
  - REM of the same operands → 0.
- DIVU 3 / 10 → 0 and REMU 3 % 10 → 3, with `out_valid` at T+3.
- Flush and back-pressure:
  - Flush during CALC: the next cycle shows IDLE and `in_ready` = 1, and no `out_valid` appears.
  - Holding `out_ready` = 0 for 5 cycles in DONE: `out_data` stays stable and `in_ready` = 0 throughout.
